// File: rtl/analog_bus_pkg.sv
// Shared types and helpers for the analog bus arbiter: FSM state encoding,
// owner index width and the rotate-priority search used at arbitration points.
package analog_bus_pkg;

    localparam int MAX_REQ = 8;
    localparam int OWNER_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OWNED  = 2'd2,
        BREAK  = 2'd3
    } bus_state_e;

    typedef struct packed {
        logic               found;
        logic [OWNER_W-1:0] idx;
    } pick_t;

    // First set request at or above ptr, wrapping at n; only the low n bits of req are live.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [OWNER_W-1:0] ptr,
                                      input int                 n);
        pick_t              res;
        int                 j;
        logic [OWNER_W-1:0] jj;
        res = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                j = int'(ptr) + i;
                if (j >= n) j = j - n;
                jj = OWNER_W'(j);
                if (!res.found && req[jj]) begin
                    res.found = 1'b1;
                    res.idx   = jj;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/analog_bus_rr_pick.sv
// Combinational rotate-priority encoder: picks the first active request
// scanning upward from ptr_i with wrap-around.
module analog_bus_rr_pick
    import analog_bus_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OWNER_W-1:0] ptr_i,
    output logic [OWNER_W-1:0] idx_o,
    output logic               found_o
);

    logic [MAX_REQ-1:0] req_ext;
    pick_t              pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        pick                   = rr_pick(req_ext, ptr_i, NUM_REQ);
    end

    assign idx_o   = pick.idx;
    assign found_o = pick.found;

endmodule

// File: rtl/analog_bus_arbiter.sv
// Round-robin owner of one shared analog bus with break-before-make switch
// enables and a settle delay before bus_ready; every output is a register.
module analog_bus_arbiter
    import analog_bus_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DEAD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] conn_en,
    output logic               bus_ready,
    output logic [OWNER_W-1:0] owner,
    output logic               busy
);

    bus_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] conn_q, conn_d;
    logic               ready_q, ready_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [OWNER_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]   timer_q, timer_d;

    logic [OWNER_W-1:0] next_ptr;
    logic [OWNER_W-1:0] pick_ptr;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_found;
    logic               owner_req;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == OWNER_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign next_ptr  = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    // BREAK exit arbitrates as if the pointer had already moved past the old owner.
    assign pick_ptr  = (state_q == BREAK) ? next_ptr : ptr_q;
    assign owner_req = |(req & onehot(owner_q));

    analog_bus_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (pick_ptr),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        conn_d  = conn_q;
        ready_d = ready_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = onehot(pick_idx);
                    owner_d = pick_idx;
                    timer_d = CNT_W'(SETTLE_CYCLES - 1);
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!owner_req) begin
                    grant_d = '0;
                    conn_d  = '0;
                    ready_d = 1'b0;
                    timer_d = CNT_W'(DEAD_CYCLES - 1);
                    state_d = BREAK;
                end else if (conn_q == '0) begin
                    // Close the switch first; the settle count starts once it is closed.
                    conn_d = onehot(owner_q);
                end else if (timer_q == '0) begin
                    ready_d = 1'b1;
                    state_d = OWNED;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    grant_d = '0;
                    conn_d  = '0;
                    ready_d = 1'b0;
                    timer_d = CNT_W'(DEAD_CYCLES - 1);
                    state_d = BREAK;
                end
            end
            BREAK: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - CNT_W'(1);
                end else begin
                    ptr_d = next_ptr;
                    if (pick_found) begin
                        grant_d = onehot(pick_idx);
                        owner_d = pick_idx;
                        timer_d = CNT_W'(SETTLE_CYCLES - 1);
                        state_d = SETTLE;
                    end else begin
                        owner_d = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                conn_d  = '0;
                ready_d = 1'b0;
                owner_d = '0;
                busy_d  = 1'b0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            conn_q  <= '0;
            ready_q <= 1'b0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            conn_q  <= conn_d;
            ready_q <= ready_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
        end
    end

    assign grant     = grant_q;
    assign conn_en   = conn_q;
    assign bus_ready = ready_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_analog_bus_arbiter.sv
// Scoreboard bench for analog_bus_arbiter: directed ownership sequences push
// expected owners/latencies; a negedge monitor pops and checks them.
module tb_analog_bus_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int DEAD_CYCLES   = 2;
    localparam int SETTLE_CYCLES = 4;
    localparam int CNT_W         = 4;

    logic         clock;
    logic         reset_n;
    logic [3:0]   req;
    logic [3:0]   grant;
    logic [3:0]   conn_en;
    logic         bus_ready;
    logic [2:0]   owner;
    logic         busy;

    analog_bus_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DEAD_CYCLES   (DEAD_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .grant     (grant),
        .conn_en   (conn_en),
        .bus_ready (bus_ready),
        .owner     (owner),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int owner;
        int ready_lat;  // grant rise to bus_ready rise, -1 = must never assert
        int gap;        // exact conn_en zero cycles before this conn_en, -1 = unchecked
        int brk;        // previous grant fall to this grant rise, -1 = unchecked
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    logic sb_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic push_exp(input int o, input int r, input int g, input int b);
        exp_t e;
        e.owner = o; e.ready_lat = r; e.gap = g; e.brk = b;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: invariants every cycle plus scoreboard events on grant/conn/ready edges.
    int         cyc = 0;
    int         g_cyc, fall_cyc, zero_run;
    logic       have_cur, ready_seen, had_conn;
    logic [3:0] prev_grant, prev_conn;
    logic       prev_ready;

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            prev_grant = '0; prev_conn = '0; prev_ready = 1'b0;
            have_cur = 1'b0; ready_seen = 1'b0; had_conn = 1'b0;
            zero_run = 0; fall_cyc = -1; g_cyc = 0;
        end else begin
            check("conn_onehot0", 32'($onehot0(conn_en)), 32'd1);
            if (bus_ready) check("ready_conn_eq_grant", 32'(conn_en), 32'(grant));
            if (conn_en != '0 && prev_conn != '0 && conn_en != prev_conn)
                check("conn_direct_switch", 32'(conn_en), 32'(prev_conn));
            if (conn_en != '0 && prev_conn == '0 && had_conn)
                check("dead_time_min", 32'(zero_run >= DEAD_CYCLES), 32'd1);

            if (sb_en && grant != '0 && prev_grant == '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("owner", 32'(owner), 32'(cur.owner));
                    check("grant_onehot", 32'(grant), 32'd1 << cur.owner);
                    if (cur.brk >= 0) check("break_len", 32'(cyc - fall_cyc), 32'(cur.brk));
                    have_cur = 1'b1; g_cyc = cyc; ready_seen = 1'b0;
                end
            end
            if (have_cur && conn_en != '0 && prev_conn == '0) begin
                check("conn_latency", 32'(cyc - g_cyc), 32'd1);
                check("conn_match", 32'(conn_en), 32'(grant));
                if (cur.gap >= 0) check("conn_gap", 32'(zero_run), 32'(cur.gap));
            end
            if (have_cur && bus_ready && !prev_ready) begin
                ready_seen = 1'b1;
                check("ready_latency", 32'(cyc - g_cyc), 32'(cur.ready_lat));
            end
            if (grant == '0 && prev_grant != '0) begin
                if (have_cur && cur.ready_lat < 0) check("early_no_ready", 32'(ready_seen), 32'd0);
                fall_cyc = cyc;
                have_cur = 1'b0;
            end

            if (conn_en == '0) zero_run++;
            else begin zero_run = 0; had_conn = 1'b1; end
            prev_grant = grant; prev_conn = conn_en; prev_ready = bus_ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req = '0; reset_n = 1'b0; sb_en = 1'b1;
        tick(2);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_conn", 32'(conn_en), 32'd0);
        check("rst_ready", 32'(bus_ready), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #2 reset_n = 1'b1;
        tick(1);

        // Single request from idle: grant +1, conn_en +2, bus_ready +6.
        req = 4'b0010; push_exp(1, 5, -1, -1);
        tick(9);
        req = '0;
        tick(6);

        // Async reset in the middle of an ownership (pointer is 2 here).
        req = 4'b0100; push_exp(2, 5, -1, -1);
        tick(8);
        check("owned_ready", 32'(bus_ready), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_conn", 32'(conn_en), 32'd0);
        check("async_ready", 32'(bus_ready), 32'd0);
        check("async_owner", 32'(owner), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        req = '0;
        tick(1);
        #2 reset_n = 1'b1;
        tick(2);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_grant", 32'(grant), 32'd0);

        // Round robin with all requests held; each owner pulses its request low.
        req = 4'b1111;
        push_exp(0, 5, -1, -1);
        push_exp(1, 5, 3, 2);
        push_exp(2, 5, 3, 2);
        push_exp(3, 5, 3, 2);
        push_exp(0, 5, 3, 2);
        for (int w = 0; w < 4; w++) begin
            tick(7);
            req[w] = 1'b0;
            tick(1);
            req[w] = 1'b1;
            tick(1);
        end
        tick(7);
        req = '0;
        tick(6);

        // Early release during SETTLE (pointer is 1): owner 0 drops, 2 waits.
        req = 4'b0001; push_exp(0, -1, -1, -1);
        tick(3);
        req = 4'b0100; push_exp(2, 5, 3, 2);
        tick(2);

        // Owner 2 releases as 3 and 0 rise together: 3 wins, then wrap to 0.
        tick(7);
        req = 4'b1001; push_exp(3, 5, 3, 2);
        tick(2);
        tick(7);
        req = 4'b0001; push_exp(0, 5, 3, 2);
        tick(2);
        tick(7);
        req = '0;
        tick(6);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Random traffic: only the invariants are checked.
        sb_en = 1'b0;
        for (int k = 0; k < 60; k++) begin
            req = 4'($urandom_range(0, 15));
            tick(int'($urandom_range(1, 12)));
        end
        req = '0;
        tick(12);
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
